instr_fetch: RTL and testbench

Instruction fetch unit between the synchronous instruction memory and the decoder. It owns the program counter, issues one-word reads to the memory, and buffers returned words in a small prefetch FIFO. It presents them to the decoder with the `instr`/`instr_valid`/`next_instr` handshake, so the decoder sees back-to-back instructions without memory bubbles. A redirect input reloads the PC and flushes all fetched and in-flight words for future jump/branch support.

---
 rtl/instr_fetch.sv | 120 ++++++++++++
 tb/tb_instr_fetch.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch unit sitting between the synchronous
// instruction memory and the decoder. Owns the program counter, issues
// one-word reads, and buffers returned words (with their addresses) in a
// small prefetch FIFO so the decoder can consume one instruction per cycle.
// A redirect reloads the PC and discards everything fetched or in flight.
module instr_fetch #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              next_instr
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_LIMIT  = OCC_W'(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [31:0]       fifo_data [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_addr;
    logic              kill;

    logic              push;
    logic              pop;
    logic              issue;
    logic [OCC_W-1:0]  occupancy;

    // Decide this cycle's push, pop and whether a new read is safe to issue.
    // The occupancy sum is deliberately conservative so a returning word
    // always has a free slot; a pop implies count >= 1, so no underflow.
    always_comb begin
        push      = inflight && !kill && !redirect;
        pop       = (count != '0) && next_instr && !redirect;
        occupancy = OCC_W'(count) + OCC_W'(inflight) + OCC_W'(push) - OCC_W'(pop);
        issue     = fetch_en && !redirect && !reset && (occupancy < OCC_LIMIT);
    end

    // Drive the memory request and present the FIFO head to the decoder.
    always_comb begin
        mem_rd_en   = issue;
        mem_addr    = pc;
        instr_valid = (count != '0);
        instr       = fifo_data[rd_ptr];
        instr_pc    = fifo_pc[rd_ptr];
    end

    // PC, in-flight tracking, kill flag, FIFO pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
            kill          <= 1'b0;
            count         <= '0;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
        end else begin
            kill     <= redirect;
            inflight <= issue;
            if (issue) begin
                inflight_addr <= pc;
            end
            if (redirect) begin
                pc     <= redirect_pc;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (issue) begin
                    pc <= pc + ADDR_W'(1);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // FIFO storage: returned word and its address land at the write pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (push) begin
            fifo_data[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]   <= inflight_addr;
        end
    end

    // The issue rule must make overflow impossible; flag it if it ever happens.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= FULL_COUNT);
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios followed by randomized stimulus, all
// checked cycle by cycle against a queue-based reference model of the fetch
// unit and a behavioural synchronous memory.
module tb_instr_fetch;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [31:0]       data;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic              clk;
    logic              reset;
    logic              fetch_en;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              next_instr;

    logic [31:0]       mem [64];

    entry_t            model_q [$];
    logic [ADDR_W-1:0] m_pc;
    bit                m_inflight;
    logic [ADDR_W-1:0] m_inf_addr;
    logic [31:0]       m_inf_data;

    int                compare_count;
    int                fail_count;
    int                rd_count;
    logic [ADDR_W-1:0] last_rd_addr;

    instr_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .next_instr  (next_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data for a read appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en === 1'b1) begin
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, compare outputs with the model, then advance
    // both the DUT and the model by one clock edge.
    task automatic applyStimulus(input bit rst, input bit fe, input bit rd,
                                 input logic [ADDR_W-1:0] rpc, input bit ni);
        bit     push;
        bit     pop;
        bit     exp_rd;
        int     occ;
        entry_t ent;

        reset       = rst;
        fetch_en    = fe;
        redirect    = rd;
        redirect_pc = rpc;
        next_instr  = ni;
        #1;

        push   = m_inflight && !rst && !rd;
        pop    = (model_q.size() != 0) && ni && !rst && !rd;
        occ    = model_q.size() + int'(m_inflight) + int'(push) - int'(pop);
        exp_rd = fe && !rst && !rd && (occ < DEPTH);

        checkOutput("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd));
        if (exp_rd) begin
            checkOutput("mem_addr", 32'(mem_addr), 32'(m_pc));
        end
        checkOutput("instr_valid", 32'(instr_valid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            checkOutput("instr", instr, model_q[0].data);
            checkOutput("instr_pc", 32'(instr_pc), 32'(model_q[0].pc));
        end
        if (mem_rd_en === 1'b1) begin
            rd_count++;
            last_rd_addr = mem_addr;
        end

        @(posedge clk);
        if (rst) begin
            model_q.delete();
            m_pc       = '0;
            m_inflight = 1'b0;
        end else if (rd) begin
            model_q.delete();
            m_pc       = rpc;
            m_inflight = 1'b0;
        end else begin
            if (pop) begin
                void'(model_q.pop_front());
            end
            if (push) begin
                ent.data = m_inf_data;
                ent.pc   = m_inf_addr;
                model_q.push_back(ent);
            end
            if (exp_rd) begin
                m_inf_addr = m_pc;
                m_inf_data = mem[m_pc];
                m_pc       = m_pc + ADDR_W'(1);
            end
            m_inflight = exp_rd;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [ADDR_W-1:0] seen [$];
        int                rd_before;
        int                ni_bias;
        bit                rst_r, fe_r, rd_r, ni_r;
        logic [ADDR_W-1:0] rpc_r;

        compare_count = 0;
        fail_count    = 0;
        rd_count      = 0;
        last_rd_addr  = '0;
        m_pc          = '0;
        m_inflight    = 1'b0;
        m_inf_addr    = '0;
        m_inf_data    = '0;
        mem_rdata     = '0;
        for (int k = 0; k < 64; k++) begin
            mem[k] = 32'h1000_0000 + 32'(k);
        end

        reset       = 1'b1;
        fetch_en    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        next_instr  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Idle cycle out of reset: everything at reset values.
        applyStimulus(0, 0, 0, '0, 0);
        checkOutput("rst_instr", instr, 32'h0);
        checkOutput("rst_instr_pc", 32'(instr_pc), 32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_rd_en", 32'(mem_rd_en), 32'h0);

        // Streaming with the decoder always ready.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(0, 1, 0, '0, 1);
            if (i == 0) begin
                checkOutput("stream_r1_valid", 32'(instr_valid), 32'h0);
            end
            if (i == 1) begin
                checkOutput("stream_r2_valid", 32'(instr_valid), 32'h1);
                checkOutput("stream_r2_instr", instr, 32'h1000_0000);
                checkOutput("stream_r2_pc", 32'(instr_pc), 32'h0);
            end
        end

        // Backpressure: exactly DEPTH reads, then the head is held.
        applyStimulus(1, 0, 0, '0, 0);
        rd_count = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 0, '0, 0);
        end
        checkOutput("bp_reads", 32'(rd_count), 32'd4);
        checkOutput("bp_last_addr", 32'(last_rd_addr), 32'd3);
        checkOutput("bp_head", instr, 32'h1000_0000);

        // One pop frees one slot: exactly one more read, address 4.
        applyStimulus(0, 1, 0, '0, 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 0, '0, 0);
        end
        checkOutput("bp_pulse_reads", 32'(rd_count), 32'd5);
        checkOutput("bp_pulse_addr", 32'(last_rd_addr), 32'd4);
        checkOutput("bp_pulse_head", instr, 32'h1000_0001);

        // Pop once more so addr 5 is in flight with three entries queued.
        applyStimulus(0, 1, 0, '0, 1);
        checkOutput("pre_redirect_addr", 32'(last_rd_addr), 32'd5);

        // Redirect to 0x20 while addr 5 returns.
        applyStimulus(0, 1, 1, 6'h20, 0);
        checkOutput("redir_t1_valid", 32'(instr_valid), 32'h0);
        applyStimulus(0, 1, 0, '0, 0);
        checkOutput("redir_t2_valid", 32'(instr_valid), 32'h0);
        applyStimulus(0, 1, 0, '0, 0);
        checkOutput("redir_t3_valid", 32'(instr_valid), 32'h1);
        checkOutput("redir_t3_instr", instr, mem[6'h20]);
        checkOutput("redir_t3_pc", 32'(instr_pc), 32'h20);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0, '0, 1);
        end

        // PC wrap: fetch from 0x3E across the top of the address space.
        applyStimulus(0, 1, 1, 6'h3E, 1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0, '0, 1);
            if (instr_valid === 1'b1 && seen.size() < 4) begin
                seen.push_back(instr_pc);
            end
        end
        checkOutput("wrap_count", 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            checkOutput("wrap_pc0", 32'(seen[0]), 32'h3E);
            checkOutput("wrap_pc1", 32'(seen[1]), 32'h3F);
            checkOutput("wrap_pc2", 32'(seen[2]), 32'h00);
            checkOutput("wrap_pc3", 32'(seen[3]), 32'h01);
        end

        // Fill, then drain with fetching disabled.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 0, '0, 0);
        end
        rd_before = rd_count;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, '0, 1);
        end
        checkOutput("fe_off_reads", 32'(rd_count - rd_before), 32'd0);
        checkOutput("fe_off_drained", 32'(instr_valid), 32'h0);

        // Reset mid-operation with a read in flight.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, '0, 1);
        end
        applyStimulus(1, 1, 0, '0, 1);
        checkOutput("midrst_valid", 32'(instr_valid), 32'h0);
        checkOutput("midrst_instr", instr, 32'h0);
        checkOutput("midrst_pc", 32'(instr_pc), 32'h0);
        checkOutput("midrst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("midrst_rd_en", 32'(mem_rd_en), 32'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1, 0, '0, 1);
            if (i == 1) begin
                checkOutput("restart_instr", instr, 32'h1000_0000);
                checkOutput("restart_pc", 32'(instr_pc), 32'h0);
            end
        end

        // Randomized traffic with fresh memory contents.
        applyStimulus(1, 0, 0, '0, 0);
        for (int k = 0; k < 64; k++) begin
            mem[k] = $urandom;
        end
        ni_bias = 2;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 32 == 0) begin
                ni_bias = int'($urandom_range(0, 4));
            end
            rst_r = ($urandom_range(0, 199) == 0);
            rd_r  = ($urandom_range(0, 24) == 0);
            fe_r  = ($urandom_range(0, 9) != 0);
            ni_r  = (int'($urandom_range(0, 3)) < ni_bias);
            rpc_r = ADDR_W'($urandom_range(0, 63));
            applyStimulus(rst_r, fe_r, rd_r, rpc_r, ni_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
